writeback_dp: RTL and testbench



---
 rtl/writeback_dp.sv | 139 +++++++++++++
 tb/tb_writeback_dp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_dp.sv
// rtl/writeback_dp.sv - writeback datapath: M/W register, load extraction, result select, mul/div merge
module writeback_dp (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        reg_write_mem_i,
    input  logic [1:0]  result_src_mem_i,
    input  logic [2:0]  funct3_mem_i,
    input  logic [31:0] alu_result_mem_i,
    input  logic [31:0] read_data_mem_i,
    input  logic [31:0] pc_next_4_mem_i,
    input  logic [4:0]  rd_a_mem_i,
    input  logic        md_valid_i,
    input  logic [4:0]  md_rd_a_i,
    input  logic [31:0] md_result_i,
    output logic        md_ready_o,
    output logic        md_stall_o,
    output logic        reg_write_wb_o,
    output logic [4:0]  rd_a_wb_o,
    output logic [31:0] result_wb_o
);
    typedef logic [31:0] word_st;
    typedef logic [4:0]  reg_e;
    localparam reg_e REG_ZERO = 5'd0;

    logic        reg_write_q;
    logic [1:0]  result_src_q;
    logic [2:0]  funct3_q;
    word_st      alu_result_q;
    word_st      read_data_q;
    word_st      pc_next_4_q;
    reg_e        rd_a_q;

    logic        buf_v;
    reg_e        buf_rd;
    word_st      buf_data;
    logic [1:0]  wait_cnt;

    logic        pw;
    logic        collision;
    logic        accept;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    word_st      load_data;
    word_st      pipe_result;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 2'd0;
            funct3_q     <= 3'd0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            pc_next_4_q  <= '0;
            rd_a_q       <= REG_ZERO;
        end else begin
            reg_write_q  <= reg_write_mem_i;
            result_src_q <= result_src_mem_i;
            funct3_q     <= funct3_mem_i;
            alu_result_q <= alu_result_mem_i;
            read_data_q  <= read_data_mem_i;
            pc_next_4_q  <= pc_next_4_mem_i;
            rd_a_q       <= rd_a_mem_i;
        end
    end

    always_comb begin
        lane_byte = read_data_q[7:0];
        case (alu_result_q[1:0])
            2'd1:    lane_byte = read_data_q[15:8];
            2'd2:    lane_byte = read_data_q[23:16];
            2'd3:    lane_byte = read_data_q[31:24];
            default: lane_byte = read_data_q[7:0];
        endcase
        lane_half = alu_result_q[1] ? read_data_q[31:16] : read_data_q[15:0];

        case (funct3_q)
            3'd0:    load_data = {{24{lane_byte[7]}}, lane_byte};
            3'd1:    load_data = {{16{lane_half[15]}}, lane_half};
            3'd4:    load_data = {24'd0, lane_byte};
            3'd5:    load_data = {16'd0, lane_half};
            default: load_data = read_data_q;
        endcase

        case (result_src_q)
            2'd1:    pipe_result = load_data;
            2'd2:    pipe_result = pc_next_4_q;
            default: pipe_result = alu_result_q;
        endcase
    end

    assign pw         = reg_write_q && (rd_a_q != REG_ZERO);
    assign collision  = pw && buf_v && (rd_a_q == buf_rd);
    assign md_ready_o = !buf_v && !rst_i;
    assign accept     = md_valid_i && md_ready_o;
    assign md_stall_o = (wait_cnt == 2'd2);

    // The pipe always owns the port; the buffer only fills otherwise-idle cycles.
    always_comb begin
        reg_write_wb_o = 1'b0;
        rd_a_wb_o      = REG_ZERO;
        result_wb_o    = '0;
        if (pw) begin
            reg_write_wb_o = 1'b1;
            rd_a_wb_o      = rd_a_q;
            result_wb_o    = pipe_result;
        end else if (buf_v) begin
            reg_write_wb_o = 1'b1;
            rd_a_wb_o      = buf_rd;
            result_wb_o    = buf_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_v    <= 1'b0;
            buf_rd   <= REG_ZERO;
            buf_data <= '0;
            wait_cnt <= 2'd0;
        end else begin
            if (buf_v) begin
                if (!pw || collision) begin
                    buf_v <= 1'b0;
                end
            end else if (accept && (md_rd_a_i != REG_ZERO)) begin
                buf_v    <= 1'b1;
                buf_rd   <= md_rd_a_i;
                buf_data <= md_result_i;
            end
            // Holds at 2 so the stall request persists until the buffer drains.
            if (buf_v && pw && !collision) begin
                if (wait_cnt != 2'd2) begin
                    wait_cnt <= wait_cnt + 2'd1;
                end
            end else begin
                wait_cnt <= 2'd0;
            end
        end
    end
endmodule

// File: tb/tb_writeback_dp.sv
// tb/tb_writeback_dp.sv - directed and randomized checks of writeback_dp against a behavioural model
module tb_writeback_dp;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        reg_write_mem_i = 1'b0;
    logic [1:0]  result_src_mem_i = '0;
    logic [2:0]  funct3_mem_i = '0;
    logic [31:0] alu_result_mem_i = '0;
    logic [31:0] read_data_mem_i = '0;
    logic [31:0] pc_next_4_mem_i = '0;
    logic [4:0]  rd_a_mem_i = '0;
    logic        md_valid_i = 1'b0;
    logic [4:0]  md_rd_a_i = '0;
    logic [31:0] md_result_i = '0;
    logic        md_ready_o;
    logic        md_stall_o;
    logic        reg_write_wb_o;
    logic [4:0]  rd_a_wb_o;
    logic [31:0] result_wb_o;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: last captured memory-stage op, pending mul/div results, blocked run length
    logic        m_we = 1'b0;
    logic [1:0]  m_src = '0;
    logic [2:0]  m_f3 = '0;
    logic [31:0] m_alu = '0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_pc4 = '0;
    logic [4:0]  m_rd = '0;
    logic [4:0]  q_rd[$];
    logic [31:0] q_data[$];
    int          blocked = 0;

    writeback_dp dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .reg_write_mem_i(reg_write_mem_i), .result_src_mem_i(result_src_mem_i),
        .funct3_mem_i(funct3_mem_i), .alu_result_mem_i(alu_result_mem_i),
        .read_data_mem_i(read_data_mem_i), .pc_next_4_mem_i(pc_next_4_mem_i),
        .rd_a_mem_i(rd_a_mem_i), .md_valid_i(md_valid_i), .md_rd_a_i(md_rd_a_i),
        .md_result_i(md_result_i), .md_ready_o(md_ready_o), .md_stall_o(md_stall_o),
        .reg_write_wb_o(reg_write_wb_o), .rd_a_wb_o(rd_a_wb_o), .result_wb_o(result_wb_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_value();
        logic [31:0] b;
        logic [31:0] h;
        b = (m_rdata >> (8 * m_alu[1:0])) & 32'hFF;
        h = (m_rdata >> (16 * m_alu[1])) & 32'hFFFF;
        if (m_src == 2'd2) return m_pc4;
        if (m_src != 2'd1) return m_alu;
        case (m_f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return m_rdata;
        endcase
    endfunction

    task automatic step();
        logic        pw;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        @(negedge clk_i);
        pw = m_we && (m_rd != 5'd0);
        e_we = 1'b0; e_rd = 5'd0; e_data = 32'd0;
        if (pw) begin
            e_we = 1'b1; e_rd = m_rd; e_data = model_value();
        end else if (q_rd.size() > 0) begin
            e_we = 1'b1; e_rd = q_rd[0]; e_data = q_data[0];
        end
        check_eq("wb_we", {31'd0, reg_write_wb_o}, {31'd0, e_we});
        check_eq("wb_rd", {27'd0, rd_a_wb_o}, {27'd0, e_rd});
        check_eq("wb_data", result_wb_o, e_data);
        check_eq("md_ready", {31'd0, md_ready_o}, {31'd0, (q_rd.size() == 0) && !rst_i});
        check_eq("md_stall", {31'd0, md_stall_o}, {31'd0, blocked >= 2});
        @(posedge clk_i);
        if (rst_i) begin
            m_we = 0; m_src = 0; m_f3 = 0; m_alu = 0; m_rdata = 0; m_pc4 = 0; m_rd = 0;
            q_rd.delete(); q_data.delete(); blocked = 0;
        end else begin
            if (q_rd.size() > 0) begin
                if (pw && m_rd != q_rd[0]) begin
                    blocked++;
                end else begin
                    void'(q_rd.pop_front()); void'(q_data.pop_front());
                    blocked = 0;
                end
            end else begin
                blocked = 0;
                if (md_valid_i && md_rd_a_i != 5'd0) begin
                    q_rd.push_back(md_rd_a_i); q_data.push_back(md_result_i);
                end
            end
            m_we = reg_write_mem_i; m_src = result_src_mem_i; m_f3 = funct3_mem_i;
            m_alu = alu_result_mem_i; m_rdata = read_data_mem_i; m_pc4 = pc_next_4_mem_i;
            m_rd = rd_a_mem_i;
        end
        #1;
    endtask

    task automatic expect_port(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] data);
        check_eq({tag, "_we"}, {31'd0, reg_write_wb_o}, {31'd0, we});
        check_eq({tag, "_rd"}, {27'd0, rd_a_wb_o}, {27'd0, rd});
        check_eq({tag, "_data"}, result_wb_o, data);
    endtask

    task automatic set_pipe(input logic we, input logic [1:0] src, input logic [2:0] f3,
                            input logic [31:0] alu, input logic [31:0] rdata,
                            input logic [31:0] pc4, input logic [4:0] rd);
        reg_write_mem_i = we; result_src_mem_i = src; funct3_mem_i = f3;
        alu_result_mem_i = alu; read_data_mem_i = rdata; pc_next_4_mem_i = pc4; rd_a_mem_i = rd;
    endtask

    task automatic set_md(input logic v, input logic [4:0] rd, input logic [31:0] data);
        md_valid_i = v; md_rd_a_i = rd; md_result_i = data;
    endtask

    initial begin
        @(posedge clk_i); #1;
        step();
        expect_port("reset", 1'b0, 5'd0, 32'd0);
        check_eq("reset_ready", {31'd0, md_ready_o}, 32'd0);
        rst_i = 1'b0;

        set_pipe(1, 2'd1, 3'd0, 32'h1001, 32'h8081_F2F3, 32'd0, 5'd5);
        step();
        expect_port("lb", 1'b1, 5'd5, 32'hFFFF_FFF2);
        set_pipe(1, 2'd1, 3'd5, 32'h1002, 32'h8081_F2F3, 32'd0, 5'd5);
        step();
        expect_port("lhu", 1'b1, 5'd5, 32'h0000_8081);
        set_pipe(1, 2'd2, 3'd2, 32'd0, 32'd0, 32'h104, 5'd1);
        step();
        expect_port("pc4", 1'b1, 5'd1, 32'h104);
        set_pipe(1, 2'd2, 3'd2, 32'd0, 32'd0, 32'h104, 5'd0);
        step();
        expect_port("x0", 1'b0, 5'd0, 32'd0);

        set_pipe(0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        set_md(1, 5'd7, 32'h1234);
        step();
        set_md(0, 5'd0, 32'd0);
        expect_port("md_idle", 1'b1, 5'd7, 32'h1234);
        check_eq("md_idle_ready_lo", {31'd0, md_ready_o}, 32'd0);
        step();
        check_eq("md_idle_ready_hi", {31'd0, md_ready_o}, 32'd1);

        set_md(1, 5'd7, 32'h5555);
        set_pipe(1, 2'd0, 3'd0, 32'h3333, 32'd0, 32'd0, 5'd3);
        step();
        set_md(0, 5'd0, 32'd0);
        expect_port("cont1", 1'b1, 5'd3, 32'h3333);
        check_eq("cont1_stall", {31'd0, md_stall_o}, 32'd0);
        set_pipe(1, 2'd0, 3'd0, 32'h4444, 32'd0, 32'd0, 5'd4);
        step();
        check_eq("cont2_stall", {31'd0, md_stall_o}, 32'd0);
        set_pipe(1, 2'd0, 3'd0, 32'h5555_0005, 32'd0, 32'd0, 5'd5);
        step();
        check_eq("cont3_stall", {31'd0, md_stall_o}, 32'd1);
        set_pipe(0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        step();
        expect_port("drain", 1'b1, 5'd7, 32'h5555);
        step();
        check_eq("drain_stall", {31'd0, md_stall_o}, 32'd0);
        expect_port("after_drain", 1'b0, 5'd0, 32'd0);

        set_md(1, 5'd9, 32'hDEAD);
        set_pipe(1, 2'd0, 3'd0, 32'hAAAA, 32'd0, 32'd0, 5'd9);
        step();
        set_md(0, 5'd0, 32'd0);
        set_pipe(0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        expect_port("collide", 1'b1, 5'd9, 32'hAAAA);
        step();
        expect_port("collide_drop", 1'b0, 5'd0, 32'd0);
        check_eq("collide_ready", {31'd0, md_ready_o}, 32'd1);

        set_md(1, 5'd12, 32'h7777);
        set_pipe(1, 2'd0, 3'd0, 32'h2222, 32'd0, 32'd0, 5'd2);
        step();
        set_md(0, 5'd0, 32'd0);
        set_pipe(0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        rst_i = 1'b1;
        check_eq("rst_ready_lo", {31'd0, md_ready_o}, 32'd0);
        step();
        expect_port("rst_mid", 1'b0, 5'd0, 32'd0);
        check_eq("rst_mid_stall", {31'd0, md_stall_o}, 32'd0);
        rst_i = 1'b0;
        step();
        expect_port("rst_after", 1'b0, 5'd0, 32'd0);
        check_eq("rst_after_ready", {31'd0, md_ready_o}, 32'd1);

        for (int i = 0; i < 600; i++) begin
            rst_i = ($urandom_range(0, 99) < 2);
            set_pipe(($urandom_range(0, 99) < 70) && !(blocked >= 2),
                     2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                     $urandom(), $urandom(), $urandom(), 5'($urandom_range(0, 7)));
            set_md($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom());
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
